// File: rtl/sh7034_rst_cpg.sv
// sh7034_rst_cpg: clock-enable prescaler and reset sequencer for the
// SH7034 on-chip peripherals (WDT, ITU, SCI).
//
// A 13-bit free-running prescaler produces single-tick enable strobes
// at /2, /64, /128, /256, /512, /1024, /4096 and /8192 of the CE_R rate.
//
// A three-state FSM (RUN, POR_HOLD, MRES_HOLD) arbitrates the external
// reset pin and the two watchdog reset requests. It holds the peripheral
// and CPU reset lines for HOLD_CYC CE_R ticks after the winning source
// releases, and it records which source caused the last reset.
//
// Handshake/timing contract: there is no valid/ready handshake. Every
// input is sampled, and every register advances, only on a rising CLK
// edge where ce_r_i=1. On all other cycles every output holds its value.
// Source priority within one tick: ext_res_ni low > wdt_pres_i > wdt_mres_i.
//
// The dbg_* outputs expose the FSM state, the hold counter and the
// prescaler. They let checkers observe internal progress without probing
// hierarchy.
module sh7034_rst_cpg #(
    parameter int unsigned HOLD_CYC = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ce_r_i,
    input  logic        ext_res_ni,
    input  logic        wdt_pres_i,
    input  logic        wdt_mres_i,
    output logic        clk2_ce_o,
    output logic        clk64_ce_o,
    output logic        clk128_ce_o,
    output logic        clk256_ce_o,
    output logic        clk512_ce_o,
    output logic        clk1024_ce_o,
    output logic        clk4096_ce_o,
    output logic        clk8192_ce_o,
    output logic        per_res_no,
    output logic        cpu_res_no,
    output logic        mres_act_o,
    output logic [1:0]  rst_cause_o,
    output logic [1:0]  dbg_state_o,
    output logic [7:0]  dbg_hc_o,
    output logic [12:0] dbg_psc_o
);

    // Hold count loaded on every reset entry / reload (valid 1..255).
    localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYC);

    localparam logic [1:0] CAUSE_EXT  = 2'b00;
    localparam logic [1:0] CAUSE_PRES = 2'b01;
    localparam logic [1:0] CAUSE_MRES = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_POR_HOLD  = 2'd1,
        ST_MRES_HOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  hc_q, hc_d;
    logic [1:0]  cause_q, cause_d;
    logic        per_res_n_q, per_res_n_d;
    logic        cpu_res_n_q, cpu_res_n_d;
    logic        mres_act_q, mres_act_d;

    logic [12:0] psc_q, psc_d;
    // Strobe vector, bit order: /2, /64, /128, /256, /512, /1024, /4096, /8192
    logic [7:0]  strobe_q, strobe_d;

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------

    // Next prescaler count and strobes. Each strobe is loaded from the
    // current count, so it is high for the tick right after the low bits
    // reach all ones. A power-on hold keeps the prescaler parked at zero.
    always_comb begin
        psc_d    = psc_q;
        strobe_d = strobe_q;
        if (ce_r_i) begin
            if (state_q == ST_POR_HOLD) begin
                psc_d    = '0;
                strobe_d = '0;
            end else begin
                psc_d       = psc_q + 13'd1;
                strobe_d[0] = &psc_q[0:0];
                strobe_d[1] = &psc_q[5:0];
                strobe_d[2] = &psc_q[6:0];
                strobe_d[3] = &psc_q[7:0];
                strobe_d[4] = &psc_q[8:0];
                strobe_d[5] = &psc_q[9:0];
                strobe_d[6] = &psc_q[11:0];
                strobe_d[7] = &psc_q[12:0];
            end
        end
    end

    // Prescaler and strobe registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            psc_q    <= '0;
            strobe_q <= '0;
        end else begin
            psc_q    <= psc_d;
            strobe_q <= strobe_d;
        end
    end

    // ------------------------------------------------------------------
    // Reset sequencer FSM
    // ------------------------------------------------------------------

    // Next state, hold count and cause. Entry rules are checked first in
    // priority order. The per-state hold behaviour applies only when no
    // entry fires. A watchdog power-on request seen during a manual hold
    // upgrades it to a power-on hold. A manual request is ignored once
    // any hold is in progress.
    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        cause_d = cause_q;
        if (ce_r_i) begin
            if (!ext_res_ni) begin
                state_d = ST_POR_HOLD;
                hc_d    = HOLD_INIT;
                cause_d = CAUSE_EXT;
            end else if (wdt_pres_i && (state_q != ST_POR_HOLD)) begin
                state_d = ST_POR_HOLD;
                hc_d    = HOLD_INIT;
                cause_d = CAUSE_PRES;
            end else if (wdt_mres_i && (state_q == ST_RUN)) begin
                state_d = ST_MRES_HOLD;
                hc_d    = HOLD_INIT;
                cause_d = CAUSE_MRES;
            end else begin
                case (state_q)
                    ST_POR_HOLD: begin
                        // The external pin is high here; only the WDT
                        // request can keep the hold count topped up.
                        if (wdt_pres_i) begin
                            hc_d = HOLD_INIT;
                        end else if (hc_q == 8'd1) begin
                            state_d = ST_RUN;
                            hc_d    = 8'd0;
                        end else begin
                            hc_d = hc_q - 8'd1;
                        end
                    end
                    ST_MRES_HOLD: begin
                        if (hc_q == 8'd1) begin
                            state_d = ST_RUN;
                            hc_d    = 8'd0;
                        end else begin
                            hc_d = hc_q - 8'd1;
                        end
                    end
                    ST_RUN: begin
                        state_d = ST_RUN;
                    end
                    default: begin
                        // Unreachable encoding: recover through a full hold.
                        state_d = ST_POR_HOLD;
                        hc_d    = HOLD_INIT;
                        cause_d = CAUSE_EXT;
                    end
                endcase
            end
        end
    end

    // Reset output decode from the next state. The registered lines then
    // change in the same tick as the state transition.
    always_comb begin
        per_res_n_d = (state_d != ST_POR_HOLD);
        cpu_res_n_d = (state_d == ST_RUN);
        mres_act_d  = (state_d == ST_MRES_HOLD);
    end

    // FSM state, hold counter, cause and reset output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_POR_HOLD;
            hc_q        <= HOLD_INIT;
            cause_q     <= CAUSE_EXT;
            per_res_n_q <= 1'b0;
            cpu_res_n_q <= 1'b0;
            mres_act_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hc_q        <= hc_d;
            cause_q     <= cause_d;
            per_res_n_q <= per_res_n_d;
            cpu_res_n_q <= cpu_res_n_d;
            mres_act_q  <= mres_act_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    assign clk2_ce_o    = strobe_q[0];
    assign clk64_ce_o   = strobe_q[1];
    assign clk128_ce_o  = strobe_q[2];
    assign clk256_ce_o  = strobe_q[3];
    assign clk512_ce_o  = strobe_q[4];
    assign clk1024_ce_o = strobe_q[5];
    assign clk4096_ce_o = strobe_q[6];
    assign clk8192_ce_o = strobe_q[7];

    assign per_res_no  = per_res_n_q;
    assign cpu_res_no  = cpu_res_n_q;
    assign mres_act_o  = mres_act_q;
    assign rst_cause_o = cause_q;

    assign dbg_state_o = state_q;
    assign dbg_hc_o    = hc_q;
    assign dbg_psc_o   = psc_q;

endmodule

// File: tb/tb_sh7034_rst_cpg.sv
// Directed testbench for sh7034_rst_cpg with HOLD_CYC=16.
// Expected values are hand-derived tick counts from reset release / entry.
module tb_sh7034_rst_cpg;

    logic        clk;
    logic        rst_n;
    logic        ce_r;
    logic        ext_res_n;
    logic        wdt_pres;
    logic        wdt_mres;
    logic        clk2_ce, clk64_ce, clk128_ce, clk256_ce;
    logic        clk512_ce, clk1024_ce, clk4096_ce, clk8192_ce;
    logic        per_res_n, cpu_res_n, mres_act;
    logic [1:0]  rst_cause;
    logic [1:0]  dbg_state;
    logic [7:0]  dbg_hc;
    logic [12:0] dbg_psc;
    logic [7:0]  strb;

    int n_checks = 0;
    int n_errors = 0;
    int ce_div   = 1;
    int cyc      = 0;
    int c0       = 0;

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_POR  = 2'd1;
    localparam logic [1:0] S_MRES = 2'd2;

    sh7034_rst_cpg #(.HOLD_CYC(16)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .ce_r_i       (ce_r),
        .ext_res_ni   (ext_res_n),
        .wdt_pres_i   (wdt_pres),
        .wdt_mres_i   (wdt_mres),
        .clk2_ce_o    (clk2_ce),
        .clk64_ce_o   (clk64_ce),
        .clk128_ce_o  (clk128_ce),
        .clk256_ce_o  (clk256_ce),
        .clk512_ce_o  (clk512_ce),
        .clk1024_ce_o (clk1024_ce),
        .clk4096_ce_o (clk4096_ce),
        .clk8192_ce_o (clk8192_ce),
        .per_res_no   (per_res_n),
        .cpu_res_no   (cpu_res_n),
        .mres_act_o   (mres_act),
        .rst_cause_o  (rst_cause),
        .dbg_state_o  (dbg_state),
        .dbg_hc_o     (dbg_hc),
        .dbg_psc_o    (dbg_psc)
    );

    assign strb = {clk8192_ce, clk4096_ce, clk1024_ce, clk512_ce,
                   clk256_ce, clk128_ce, clk64_ce, clk2_ce};

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One CE_R tick; with ce_div>1 the tick is preceded by idle clocks.
    task automatic tick();
        for (int i = 1; i < ce_div; i++) begin
            ce_r = 1'b0;
            @(posedge clk); #1;
        end
        ce_r = 1'b1;
        @(posedge clk); #1;
        if (ce_div > 1) ce_r = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n = 1'b0; ce_r = 1'b1; ext_res_n = 1'b1;
        wdt_pres = 1'b0; wdt_mres = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // ---- reset state
        check("rst_per", 32'(per_res_n), 32'd0);
        check("rst_cpu", 32'(cpu_res_n), 32'd0);
        check("rst_mres", 32'(mres_act), 32'd0);
        check("rst_cause", 32'(rst_cause), 32'd0);
        check("rst_strb", 32'(strb), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(S_POR));
        check("rst_hc", 32'(dbg_hc), 32'd16);
        rst_n = 1'b1;

        // ---- power-on hold for 16 ticks
        for (int t = 1; t <= 15; t++) begin
            tick();
            check("por_per_low", 32'(per_res_n), 32'd0);
        end
        check("por_hc_last", 32'(dbg_hc), 32'd1);
        tick();
        check("rel_per", 32'(per_res_n), 32'd1);
        check("rel_cpu", 32'(cpu_res_n), 32'd1);
        check("rel_cause", 32'(rst_cause), 32'd0);
        check("rel_psc", 32'(dbg_psc), 32'd0);

        // ---- strobes from release
        tick();
        check("r1_strb", 32'(strb), 32'h00);
        tick();
        check("r2_strb", 32'(strb), 32'h01);
        ticks(61);
        check("r63_strb", 32'(strb), 32'h00);
        tick();
        check("r64_strb", 32'(strb), 32'h03);
        ticks(8191 - 64);
        check("r8191_strb", 32'(strb), 32'h00);
        tick();
        check("r8192_strb", 32'(strb), 32'hFF);
        check("r8192_psc", 32'(dbg_psc), 32'd0);

        // ---- CE_R every 3rd clock
        ce_div = 3;
        c0 = cyc;
        ticks(63);
        check("div3_c64_low", 32'(clk64_ce), 32'd0);
        tick();
        check("div3_strb", 32'(strb), 32'h03);
        check("div3_period", 32'(cyc - c0), 32'd192);
        ce_r = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("idle_strb", 32'(strb), 32'h03);
        check("idle_psc", 32'(dbg_psc), 32'd64);
        check("idle_state", 32'(dbg_state), 32'(S_RUN));
        ce_div = 1;
        ce_r = 1'b1;

        // ---- WDT power-on request for 5 ticks
        wdt_pres = 1'b1;
        tick();
        check("pres_state", 32'(dbg_state), 32'(S_POR));
        check("pres_per", 32'(per_res_n), 32'd0);
        check("pres_cpu", 32'(cpu_res_n), 32'd0);
        check("pres_cause", 32'(rst_cause), 32'd1);
        check("pres_psc_entry", 32'(dbg_psc), 32'd65);
        ticks(4);
        check("pres_hc_reload", 32'(dbg_hc), 32'd16);
        check("pres_psc_clr", 32'(dbg_psc), 32'd0);
        check("pres_strb_clr", 32'(strb), 32'h00);
        wdt_pres = 1'b0;
        ticks(15);
        check("pres_t20_per", 32'(per_res_n), 32'd0);
        check("pres_t20_hc", 32'(dbg_hc), 32'd1);
        tick();
        check("pres_rel_per", 32'(per_res_n), 32'd1);
        check("pres_rel_cpu", 32'(cpu_res_n), 32'd1);
        check("pres_rel_cause", 32'(rst_cause), 32'd1);

        // ---- WDT manual request for 1 tick
        wdt_mres = 1'b1;
        tick();
        wdt_mres = 1'b0;
        check("mres_state", 32'(dbg_state), 32'(S_MRES));
        check("mres_cpu", 32'(cpu_res_n), 32'd0);
        check("mres_per", 32'(per_res_n), 32'd1);
        check("mres_act", 32'(mres_act), 32'd1);
        check("mres_cause", 32'(rst_cause), 32'd2);
        ticks(15);
        check("mres_t15_cpu", 32'(cpu_res_n), 32'd0);
        check("mres_t15_act", 32'(mres_act), 32'd1);
        check("mres_t15_psc", 32'(dbg_psc), 32'd16);
        check("mres_t15_c2", 32'(clk2_ce), 32'd1);
        tick();
        check("mres_rel_cpu", 32'(cpu_res_n), 32'd1);
        check("mres_rel_act", 32'(mres_act), 32'd0);
        check("mres_rel_psc", 32'(dbg_psc), 32'd17);
        check("mres_rel_cause", 32'(rst_cause), 32'd2);

        // ---- manual reset upgraded by power-on request 4 ticks later
        wdt_mres = 1'b1;
        tick();
        wdt_mres = 1'b0;
        ticks(3);
        check("upg_pre_state", 32'(dbg_state), 32'(S_MRES));
        check("upg_pre_hc", 32'(dbg_hc), 32'd13);
        wdt_pres = 1'b1;
        tick();
        wdt_pres = 1'b0;
        check("upg_state", 32'(dbg_state), 32'(S_POR));
        check("upg_per", 32'(per_res_n), 32'd0);
        check("upg_act", 32'(mres_act), 32'd0);
        check("upg_cause", 32'(rst_cause), 32'd1);
        check("upg_hc", 32'(dbg_hc), 32'd16);
        ticks(15);
        check("upg_t15_per", 32'(per_res_n), 32'd0);
        tick();
        check("upg_rel_per", 32'(per_res_n), 32'd1);
        check("upg_rel_cpu", 32'(cpu_res_n), 32'd1);

        // ---- asynchronous RST_N mid-run
        #2;
        rst_n = 1'b0;
        #1;
        check("async_per", 32'(per_res_n), 32'd0);
        check("async_cpu", 32'(cpu_res_n), 32'd0);
        check("async_cause", 32'(rst_cause), 32'd0);
        check("async_state", 32'(dbg_state), 32'(S_POR));
        check("async_hc", 32'(dbg_hc), 32'd16);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ticks(16);
        check("async_rel_per", 32'(per_res_n), 32'd1);

        // ---- all three sources together, then external held 100 ticks
        ext_res_n = 1'b0; wdt_pres = 1'b1; wdt_mres = 1'b1;
        tick();
        wdt_pres = 1'b0; wdt_mres = 1'b0;
        check("all_cause", 32'(rst_cause), 32'd0);
        check("all_state", 32'(dbg_state), 32'(S_POR));
        check("all_per", 32'(per_res_n), 32'd0);
        ticks(99);
        check("ext_hold_hc", 32'(dbg_hc), 32'd16);
        ext_res_n = 1'b1;
        ticks(15);
        check("ext_t15_per", 32'(per_res_n), 32'd0);
        check("ext_t15_hc", 32'(dbg_hc), 32'd1);
        tick();
        check("ext_rel_per", 32'(per_res_n), 32'd1);
        check("ext_rel_cpu", 32'(cpu_res_n), 32'd1);
        ticks(3);
        check("ext_cause_hold", 32'(rst_cause), 32'd0);
        check("ext_run_state", 32'(dbg_state), 32'(S_RUN));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
